cache_axi_bridge: RTL and testbench
===================================

Name: cache_axi_bridge

Overview:
- Responder end of the cache-to-interface call/return handshake used by the instruction cache and data cache.
- Accepts single-word fetches from the instruction cache, and single reads or writes from the data cache.
- Converts each one to a single-beat AXI3 transaction on the CPU's external bus.
- Returns the result as a one-cycle return_ready pulse.
- Sits between both caches and the SoC AXI port in the CPU top level.

Parameters:
- ID_INST, 4'd0, ARID used for instruction fetches.
- ID_DATA, 4'd1, ARID/AWID used for data accesses.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- inst_call_begin  in  1  one-cycle fetch request pulse
- inst_addr  in  32  fetch address, valid only in the call_begin cycle
- inst_return_ready  out  1  one-cycle fetch-done pulse
- inst_rdata  out  32  fetched word, valid with inst_return_ready
- data_call_begin  in  1  one-cycle data request pulse
- data_enable  in  1  data request in progress
- data_wen  in  1  1 = write, 0 = read
- data_rsize  in  3  read size: 0 = byte, 1 = half, 2 = word
- data_wsize  in  3  write size, same encoding as data_rsize
- data_raddr  in  32  read address
- data_waddr  in  32  write address
- data_wdata  in  32  write data, already lane-aligned
- data_return_ready  out  1  one-cycle data-done pulse
- data_rdata  out  32  read word, valid with data_return_ready
- arid/araddr/arlen/arsize/arvalid  out  4/32/4/3/1  AXI read address channel
- arready  in  1  AXI read address ready
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data channel
- rready  out  1  AXI read data ready
- awid/awaddr/awlen/awsize/awvalid  out  4/32/4/3/1  AXI write address channel
- awready  in  1  AXI write address ready
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel
- wready  in  1  AXI write data ready
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - Every output is 0, including all valid/ready signals, rdata outputs and addresses.
  - Both FSMs go to IDLE; pending flags clear.
  - Reset mid-transaction abandons the transaction; no return pulse is produced.
- Request capture:
  - On data_call_begin, latch wen, size, addr and wdata into a pending data slot.
  - On inst_call_begin, latch inst_addr into a pending inst slot.
  - Latching is unconditional: the inst address is zeroed by the requester one cycle later.
  - A new call_begin while that requester's slot is already pending is a protocol violation; behaviour is undefined and it is flagged by a simulation assertion.
- Read FSM (RD_IDLE -> RD_AR -> RD_R -> RD_IDLE):
  - RD_IDLE: if a data-read is pending, select it, otherwise an inst fetch if pending. Data has priority when both are pending in the same cycle. Drive arid, araddr, arsize and arvalid = 1, then go to RD_AR.
  - Inst fetches use arsize = 2. Data reads use arsize = data_rsize.
  - RD_AR: hold arvalid and all AR fields stable until arready = 1; then arvalid = 0, rready = 1, go to RD_R.
  - RD_R: on rvalid = 1 and rready = 1, capture rdata into inst_rdata or data_rdata, pulse the matching return_ready for exactly one cycle, clear that pending slot, drop rready, and go to RD_IDLE.
  - rresp is ignored.
- Write FSM (WR_IDLE -> WR_AW_W -> WR_B -> WR_IDLE):
  - WR_IDLE: when a data-write is pending, assert awvalid = 1 and wvalid = 1 together, with wlast = 1 and awlen = 0.
  - WR_AW_W: awvalid and wvalid each drop independently on their own handshake. Once both have completed, set bready = 1 and go to WR_B.
  - WR_B: on bvalid = 1, pulse data_return_ready for one cycle (data_rdata = 0), clear the slot, drop bready, and go to WR_IDLE.
- wstrb:
  - word: 4'b1111
  - half: addr[1] ? 4'b1100 : 4'b0011
  - byte: 4'b0001 << addr[1:0]
  - wdata is passed through unchanged.
- arlen and awlen are always 0.
- Only one read is outstanding at a time. An inst read may overlap a data write.
- Latency: return_ready is never earlier than 2 cycles after the call_begin cycle. This is required by the data cache polling return_ready from its second cycle.
- inst_rdata and data_rdata hold their value until the next capture.

Decomposition:
- Shared package constants:
  - size codes (SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2)
  - read FSM state encodings
  - write FSM state encodings
  - AXI burst/len constants
- One natural sub-module: axi_wstrb_gen (size, addr[1:0] -> wstrb), which is purely combinational.
- The FSMs stay in the top module.

Test Plan:
1. Inst fetch 0xBFC00000, arready after 1 cycle, rvalid with rdata = 0x3C08BFAF after 2 cycles -> araddr = 0xBFC00000, arid = 0, arsize = 2; inst_return_ready pulses exactly 1 cycle with inst_rdata = 0x3C08BFAF.
2. Data byte write addr 0x80000003, wdata = 0xAB000000; awready held off 3 cycles, wready immediate -> wstrb = 4'b1000, wvalid drops after 1 cycle, awvalid held 4 cycles; data_return_ready pulses 1 cycle after bvalid.
3. inst_call_begin and data read call_begin in the same cycle -> data AR issued first (arid = 1); the inst AR issues only after data_return_ready; both return correct rdata.
4. Data half write to 0x80001002 overlapping an inst fetch -> AR and AW are outstanding concurrently; wstrb = 4'b1100; each requester gets its own single pulse.
5. Reset (resetn = 0) asserted while in RD_R -> all outputs 0 the next cycle, no return pulse; a subsequent fetch completes normally.
6. arready and rvalid both returned in the minimum possible cycles -> return_ready is asserted ≥ 2 cycles after call_begin.

Source files
------------

// File: rtl/cache_axi_bridge_pkg.sv
// Shared constants and types for the cache-to-AXI responder bridge.
// Size codes follow the cache side encoding, which matches AXI AxSIZE for 1/2/4 bytes.
package cache_axi_bridge_pkg;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_AR   = 2'd1;
   localparam logic [1:0] RD_R    = 2'd2;

   localparam logic [1:0] WR_IDLE = 2'd0;
   localparam logic [1:0] WR_AW_W = 2'd1;
   localparam logic [1:0] WR_B    = 2'd2;

   // Every transaction is a single beat.
   localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

   typedef struct packed {
      logic        wen;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } data_req_t;

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI3 single-beat bus between the bridge (master) and the SoC port (slave).
interface cache_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bvalid,
      input  bready
   );
endinterface

// File: rtl/cache_axi_bridge_wstrb_gen.sv
// Byte-lane strobe for a single-beat write; wdata arrives already lane-aligned.
module axi_wstrb_gen
   import cache_axi_bridge_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);
   always_comb begin
      wstrb = 4'b1111;
      case (size)
         SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
         SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   wstrb = 4'b1111;
      endcase
   end
endmodule

// File: rtl/cache_axi_bridge.sv
// Responder for the icache/dcache call/return handshake; each request becomes one
// single-beat AXI3 transaction. One read outstanding at a time; a write may overlap it.
module cache_axi_bridge
   import cache_axi_bridge_pkg::*;
#(
   parameter logic [3:0] ID_INST = 4'd0,
   parameter logic [3:0] ID_DATA = 4'd1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_call_begin,
   input  logic [31:0]       inst_addr,
   output logic              inst_return_ready,
   output logic [31:0]       inst_rdata,
   input  logic              data_call_begin,
   input  logic              data_enable,
   input  logic              data_wen,
   input  logic [2:0]        data_rsize,
   input  logic [2:0]        data_wsize,
   input  logic [31:0]       data_raddr,
   input  logic [31:0]       data_waddr,
   input  logic [31:0]       data_wdata,
   output logic              data_return_ready,
   output logic [31:0]       data_rdata,
   cache_axi_bridge_if.master axi
);
   logic        inst_pend_reg;
   logic [31:0] inst_addr_reg;
   logic        data_pend_reg;
   data_req_t   data_req_reg;
   logic [1:0]  rd_state_reg;
   logic        rd_sel_data_reg;
   logic [1:0]  wr_state_reg;
   logic [3:0]  arid_reg;
   logic [31:0] araddr_reg;
   logic [2:0]  arsize_reg;
   logic        arvalid_reg;
   logic        rready_reg;
   logic [3:0]  awid_reg;
   logic [31:0] awaddr_reg;
   logic [2:0]  awsize_reg;
   logic        awvalid_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  wstrb_reg;
   logic        wvalid_reg;
   logic        bready_reg;
   logic        inst_return_ready_reg;
   logic [31:0] inst_rdata_reg;
   logic        data_return_ready_reg;
   logic [31:0] data_rdata_reg;
   logic [3:0]  strb_next;
   logic        unused_in;

   axi_wstrb_gen u_wstrb (
      .size    (data_req_reg.size),
      .addr_lo (data_req_reg.addr[1:0]),
      .wstrb   (strb_next)
   );

   // Read response id/resp/last carry nothing we need: one read in flight, errors ignored.
   assign unused_in = ^{data_enable, axi.rid, axi.rresp, axi.rlast};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         inst_pend_reg         <= 1'b0;
         inst_addr_reg         <= '0;
         data_pend_reg         <= 1'b0;
         data_req_reg          <= '0;
         rd_state_reg          <= RD_IDLE;
         rd_sel_data_reg       <= 1'b0;
         wr_state_reg          <= WR_IDLE;
         arid_reg              <= '0;
         araddr_reg            <= '0;
         arsize_reg            <= '0;
         arvalid_reg           <= 1'b0;
         rready_reg            <= 1'b0;
         awid_reg              <= '0;
         awaddr_reg            <= '0;
         awsize_reg            <= '0;
         awvalid_reg           <= 1'b0;
         wdata_reg             <= '0;
         wstrb_reg             <= '0;
         wvalid_reg            <= 1'b0;
         bready_reg            <= 1'b0;
         inst_return_ready_reg <= 1'b0;
         inst_rdata_reg        <= '0;
         data_return_ready_reg <= 1'b0;
         data_rdata_reg        <= '0;
      end else begin
         inst_return_ready_reg <= 1'b0;
         data_return_ready_reg <= 1'b0;

         case (rd_state_reg)
            RD_IDLE: begin
               if (data_pend_reg && !data_req_reg.wen) begin
                  rd_sel_data_reg <= 1'b1;
                  arid_reg        <= ID_DATA;
                  araddr_reg      <= data_req_reg.addr;
                  arsize_reg      <= data_req_reg.size;
                  arvalid_reg     <= 1'b1;
                  rd_state_reg    <= RD_AR;
               end else if (inst_pend_reg) begin
                  rd_sel_data_reg <= 1'b0;
                  arid_reg        <= ID_INST;
                  araddr_reg      <= inst_addr_reg;
                  arsize_reg      <= SIZE_WORD;
                  arvalid_reg     <= 1'b1;
                  rd_state_reg    <= RD_AR;
               end
            end
            RD_AR: begin
               if (axi.arready) begin
                  arvalid_reg  <= 1'b0;
                  rready_reg   <= 1'b1;
                  rd_state_reg <= RD_R;
               end
            end
            RD_R: begin
               if (axi.rvalid) begin
                  rready_reg   <= 1'b0;
                  rd_state_reg <= RD_IDLE;
                  if (rd_sel_data_reg) begin
                     data_rdata_reg        <= axi.rdata;
                     data_return_ready_reg <= 1'b1;
                     data_pend_reg         <= 1'b0;
                  end else begin
                     inst_rdata_reg        <= axi.rdata;
                     inst_return_ready_reg <= 1'b1;
                     inst_pend_reg         <= 1'b0;
                  end
               end
            end
            default: rd_state_reg <= RD_IDLE;
         endcase

         case (wr_state_reg)
            WR_IDLE: begin
               if (data_pend_reg && data_req_reg.wen) begin
                  awid_reg     <= ID_DATA;
                  awaddr_reg   <= data_req_reg.addr;
                  awsize_reg   <= data_req_reg.size;
                  awvalid_reg  <= 1'b1;
                  wdata_reg    <= data_req_reg.wdata;
                  wstrb_reg    <= strb_next;
                  wvalid_reg   <= 1'b1;
                  wr_state_reg <= WR_AW_W;
               end
            end
            WR_AW_W: begin
               // AW and W complete independently; B is awaited once both are done.
               if (axi.awready) awvalid_reg <= 1'b0;
               if (axi.wready)  wvalid_reg  <= 1'b0;
               if ((!awvalid_reg || axi.awready) && (!wvalid_reg || axi.wready)) begin
                  bready_reg   <= 1'b1;
                  wr_state_reg <= WR_B;
               end
            end
            WR_B: begin
               if (axi.bvalid) begin
                  bready_reg            <= 1'b0;
                  data_rdata_reg        <= '0;
                  data_return_ready_reg <= 1'b1;
                  data_pend_reg         <= 1'b0;
                  wr_state_reg          <= WR_IDLE;
               end
            end
            default: wr_state_reg <= WR_IDLE;
         endcase

         // Capture last so a new request wins over a slot clear in the same cycle.
         if (inst_call_begin) begin
            inst_pend_reg <= 1'b1;
            inst_addr_reg <= inst_addr;
         end
         if (data_call_begin) begin
            data_pend_reg       <= 1'b1;
            data_req_reg.wen    <= data_wen;
            data_req_reg.size   <= data_wen ? data_wsize : data_rsize;
            data_req_reg.addr   <= data_wen ? data_waddr : data_raddr;
            data_req_reg.wdata  <= data_wdata;
         end
      end
   end

   assign inst_return_ready = inst_return_ready_reg;
   assign inst_rdata        = inst_rdata_reg;
   assign data_return_ready = data_return_ready_reg;
   assign data_rdata        = data_rdata_reg;

   assign axi.arid    = arid_reg;
   assign axi.araddr  = araddr_reg;
   assign axi.arlen   = AXI_LEN_SINGLE;
   assign axi.arsize  = arsize_reg;
   assign axi.arvalid = arvalid_reg;
   assign axi.rready  = rready_reg;
   assign axi.awid    = awid_reg;
   assign axi.awaddr  = awaddr_reg;
   assign axi.awlen   = AXI_LEN_SINGLE;
   assign axi.awsize  = awsize_reg;
   assign axi.awvalid = awvalid_reg;
   assign axi.wdata   = wdata_reg;
   assign axi.wstrb   = wstrb_reg;
   assign axi.wlast   = wvalid_reg;
   assign axi.wvalid  = wvalid_reg;
   assign axi.bready  = bready_reg;

   a_inst_no_overlap: assert property (@(posedge clk) disable iff (!resetn)
      inst_call_begin |-> !inst_pend_reg)
      else $error("inst_call_begin while a fetch is pending");
   a_data_no_overlap: assert property (@(posedge clk) disable iff (!resetn)
      data_call_begin |-> !data_pend_reg)
      else $error("data_call_begin while a data access is pending");

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: AXI slave processes plus a return-pulse scoreboard.
module tb_cache_axi_bridge;
   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_call_begin, data_call_begin, data_enable, data_wen;
   logic [31:0] inst_addr, data_raddr, data_waddr, data_wdata;
   logic [2:0]  data_rsize, data_wsize;
   logic        inst_return_ready, data_return_ready;
   logic [31:0] inst_rdata, data_rdata;

   cache_axi_bridge_if axi ();

   cache_axi_bridge dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_call_begin   (inst_call_begin),
      .inst_addr         (inst_addr),
      .inst_return_ready (inst_return_ready),
      .inst_rdata        (inst_rdata),
      .data_call_begin   (data_call_begin),
      .data_enable       (data_enable),
      .data_wen          (data_wen),
      .data_rsize        (data_rsize),
      .data_wsize        (data_wsize),
      .data_raddr        (data_raddr),
      .data_waddr        (data_waddr),
      .data_wdata        (data_wdata),
      .data_return_ready (data_return_ready),
      .data_rdata        (data_rdata),
      .axi               (axi)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ar_delay;
      int          r_delay;
      logic [31:0] data;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
   } rd_txn_t;

   typedef struct {
      int          aw_delay;
      int          w_delay;
      int          b_delay;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strb;
      logic [31:0] wdata;
      int          aw_cyc;
      int          w_cyc;
   } wr_txn_t;

   typedef struct {
      logic [31:0] data;
      int          call_cyc;
   } ret_t;

   rd_txn_t rd_q[$];
   wr_txn_t wr_q[$];
   ret_t    inst_sb[$];
   ret_t    data_sb[$];

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic saw_overlap = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_cache"}, 256'({inst_return_ready, inst_rdata, data_return_ready, data_rdata}), 256'(0));
      check({name, "_ar"}, 256'({axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arvalid, axi.rready}), 256'(0));
      check({name, "_aw"}, 256'({axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awvalid}), 256'(0));
      check({name, "_w"}, 256'({axi.wdata, axi.wstrb, axi.wlast, axi.wvalid, axi.bready}), 256'(0));
   endtask

   // Called at a negedge; the request is held for exactly one cycle.
   task automatic issue(input logic do_inst, input logic [31:0] iaddr,
                        input logic do_data, input logic wen, input logic [2:0] size,
                        input logic [31:0] daddr, input logic [31:0] wdata);
      inst_call_begin = do_inst;
      inst_addr       = do_inst ? iaddr : 32'h0;
      data_call_begin = do_data;
      data_enable     = do_data;
      data_wen        = wen;
      data_rsize      = wen ? ((size == 3'd2) ? 3'd0 : 3'd2) : size;
      data_wsize      = wen ? size : ((size == 3'd2) ? 3'd0 : 3'd2);
      data_raddr      = wen ? 32'hDEAD_BEEC : daddr;
      data_waddr      = wen ? daddr : 32'hDEAD_BEEC;
      data_wdata      = wdata;
      @(negedge clk);
      inst_call_begin = 1'b0;
      inst_addr       = 32'h0;
      data_call_begin = 1'b0;
      data_enable     = 1'b0;
      data_wen        = 1'b0;
      data_wdata      = 32'h0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((inst_sb.size() + data_sb.size() + rd_q.size() + wr_q.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_within_budget", 256'(n < 300), 256'(1));
      repeat (3) @(negedge clk);
   endtask

   // Read-channel slave: per transaction checks AR fields, then answers with the queued data.
   initial begin : rd_slave
      rd_txn_t t;
      int      n;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
      axi.rid = '0; axi.rresp = '0; axi.rlast = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn && axi.arvalid) begin
            check("ar_expected", 256'(rd_q.size() != 0), 256'(1));
            if (rd_q.size() == 0) continue;
            t = rd_q.pop_front();
            check("arid", 256'(axi.arid), 256'(t.id));
            check("araddr", 256'(axi.araddr), 256'(t.addr));
            check("arsize_arlen", 256'({axi.arsize, axi.arlen}), 256'({t.size, 4'd0}));
            n = 0;
            while (n < t.ar_delay && resetn) begin @(negedge clk); n++; end
            if (!resetn) continue;
            check("ar_held", 256'({axi.arvalid, axi.arid, axi.araddr}), 256'({1'b1, t.id, t.addr}));
            axi.arready = 1'b1;
            @(negedge clk);
            axi.arready = 1'b0;
            check("ar_done_rready", 256'({axi.arvalid, axi.rready}), 256'(2'b01));
            n = 0;
            while (n < t.r_delay && resetn) begin @(negedge clk); n++; end
            if (!resetn) continue;
            axi.rvalid = 1'b1; axi.rdata = t.data; axi.rid = t.id; axi.rlast = 1'b1;
            @(negedge clk);
            axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0;
            check("rready_dropped", 256'(axi.rready), 256'(0));
         end
      end
   end

   // Write-channel slave: independent AW/W ready delays, counts valid cycles, then B.
   initial begin : wr_slave
      wr_txn_t t;
      int      cnt, aw_cyc, w_cyc, n;
      logic    aw_done, w_done;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn && (axi.awvalid || axi.wvalid)) begin
            check("aw_expected", 256'(wr_q.size() != 0), 256'(1));
            if (wr_q.size() == 0) continue;
            t = wr_q.pop_front();
            check("awaddr", 256'(axi.awaddr), 256'(t.addr));
            check("awsize", 256'(axi.awsize), 256'(t.size));
            check("wstrb", 256'(axi.wstrb), 256'(t.strb));
            check("wdata", 256'(axi.wdata), 256'(t.wdata));
            check("awid_awlen_wlast", 256'({axi.awid, axi.awlen, axi.wlast}), 256'({4'd1, 4'd0, 1'b1}));
            cnt = 0; aw_cyc = 0; w_cyc = 0; aw_done = 1'b0; w_done = 1'b0;
            while (!(aw_done && w_done) && resetn && cnt < 50) begin
               if (axi.awvalid) aw_cyc++;
               if (axi.wvalid) w_cyc++;
               axi.awready = !aw_done && (cnt >= t.aw_delay);
               axi.wready  = !w_done && (cnt >= t.w_delay);
               if (axi.awvalid && axi.awready) aw_done = 1'b1;
               if (axi.wvalid && axi.wready) w_done = 1'b1;
               @(negedge clk);
               cnt++;
            end
            axi.awready = 1'b0; axi.wready = 1'b0;
            if (!resetn) continue;
            check("awvalid_cycles", 256'(aw_cyc), 256'(t.aw_cyc));
            check("wvalid_cycles", 256'(w_cyc), 256'(t.w_cyc));
            check("bready_up", 256'({axi.awvalid, axi.wvalid, axi.bready}), 256'(3'b001));
            n = 0;
            while (n < t.b_delay && resetn) begin @(negedge clk); n++; end
            if (!resetn) continue;
            axi.bvalid = 1'b1;
            @(negedge clk);
            axi.bvalid = 1'b0;
            check("b_done_pulse", 256'({axi.bready, data_return_ready}), 256'(2'b01));
         end
      end
   end

   // Scoreboard monitor: every return pulse pops one expectation.
   initial begin : monitor
      ret_t r;
      forever begin
         @(negedge clk);
         if (axi.arvalid && axi.awvalid) saw_overlap = 1'b1;
         if (inst_return_ready) begin
            check("inst_pulse_expected", 256'(inst_sb.size() != 0), 256'(1));
            if (inst_sb.size() != 0) begin
               r = inst_sb.pop_front();
               check("inst_rdata", 256'(inst_rdata), 256'(r.data));
               check("inst_latency", 256'((cyc - r.call_cyc) >= 2), 256'(1));
               $display("inst return rdata=%h latency=%0d", inst_rdata, cyc - r.call_cyc);
            end
         end
         if (data_return_ready) begin
            check("data_pulse_expected", 256'(data_sb.size() != 0), 256'(1));
            if (data_sb.size() != 0) begin
               r = data_sb.pop_front();
               check("data_rdata", 256'(data_rdata), 256'(r.data));
               check("data_latency", 256'((cyc - r.call_cyc) >= 2), 256'(1));
               $display("data return rdata=%h latency=%0d", data_rdata, cyc - r.call_cyc);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      resetn = 1'b0;
      inst_call_begin = 1'b0; inst_addr = '0;
      data_call_begin = 1'b0; data_enable = 1'b0; data_wen = 1'b0;
      data_rsize = '0; data_wsize = '0; data_raddr = '0; data_waddr = '0; data_wdata = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;
      @(negedge clk);

      // 1: plain fetch
      rd_q.push_back('{1, 2, 32'h3C08_BFAF, 4'd0, 32'hBFC0_0000, 3'd2});
      inst_sb.push_back('{32'h3C08_BFAF, cyc});
      issue(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      wait_idle();

      // 3: simultaneous fetch and data read, data first
      rd_q.push_back('{0, 1, 32'h1122_3344, 4'd1, 32'h8000_0102, 3'd1});
      rd_q.push_back('{0, 1, 32'h2408_0001, 4'd0, 32'hBFC0_0004, 3'd2});
      data_sb.push_back('{32'h1122_3344, cyc});
      inst_sb.push_back('{32'h2408_0001, cyc});
      issue(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 3'd1, 32'h8000_0102, 32'h0);
      wait_idle();

      // 2: byte write, AW held off 3 cycles, W immediate
      wr_q.push_back('{3, 0, 1, 32'h8000_0003, 3'd0, 4'b1000, 32'hAB00_0000, 4, 1});
      data_sb.push_back('{32'h0, cyc});
      issue(1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 32'h8000_0003, 32'hAB00_0000);
      wait_idle();

      // 4: half write overlapping a fetch
      saw_overlap = 1'b0;
      wr_q.push_back('{1, 2, 0, 32'h8000_1002, 3'd1, 4'b1100, 32'h5A5A_0000, 2, 3});
      rd_q.push_back('{2, 3, 32'h8D09_0000, 4'd0, 32'hBFC0_0008, 3'd2});
      data_sb.push_back('{32'h0, cyc});
      inst_sb.push_back('{32'h8D09_0000, cyc});
      issue(1'b1, 32'hBFC0_0008, 1'b1, 1'b1, 3'd1, 32'h8000_1002, 32'h5A5A_0000);
      wait_idle();
      check("ar_aw_overlap", 256'(saw_overlap), 256'(1));

      // 5: reset while waiting in RD_R; no pulse may follow
      check("inst_rdata_held", 256'(inst_rdata), 256'(32'h8D09_0000));
      rd_q.push_back('{0, 40, 32'hFFFF_FFFF, 4'd0, 32'hBFC0_000C, 3'd2});
      issue(1'b1, 32'hBFC0_000C, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      n = 0;
      while (!axi.rready && n < 50) begin @(negedge clk); n++; end
      check("reached_rd_r", 256'(axi.rready), 256'(1));
      resetn = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (6) @(negedge clk);

      // 6: minimum-latency fetch, then minimum-latency data read
      rd_q.push_back('{0, 0, 32'h0000_000F, 4'd0, 32'hBFC0_0010, 3'd2});
      inst_sb.push_back('{32'h0000_000F, cyc});
      issue(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      wait_idle();
      rd_q.push_back('{0, 0, 32'hCAFE_F00D, 4'd1, 32'h8000_0004, 3'd2});
      data_sb.push_back('{32'hCAFE_F00D, cyc});
      issue(1'b0, 32'h0, 1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
